// File: rtl/bnn_ocr_pkg.sv
// Shared types and defaults for the OCR control path: sequencer state
// encoding and the frame/result geometry used by the sequencer.
package bnn_ocr_pkg;

    // Sequencer states; the numeric values are visible on state_dbg.
    typedef enum logic [2:0] {
        CLEAR     = 3'd0,
        LOAD      = 3'd1,
        WAIT_FULL = 3'd2,
        INFER     = 3'd3,
        WAIT_DONE = 3'd4,
        RESULT    = 3'd5
    } seq_state_t;

    // 900 pixel bits packed into bytes; the last byte carries 4 pixels.
    localparam int IMG_BYTES_C     = 113;
    localparam int RESULT_W_C      = 4;
    localparam int LOAD_TIMEOUT_C  = 1_000_000;
    localparam int INFER_TIMEOUT_C = 65_536;

endpackage

// File: rtl/timeout_counter.sv
// Saturating watchdog counter. clear zeroes it, enable advances it, and
// reached is high in the cycle whose closing edge brings the count to
// LIMIT, so the owner can abort on that same edge.
module timeout_counter #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic reached
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_C = W'(LIMIT);
    localparam logic [W-1:0] LAST_C  = W'(LIMIT - 1);

    logic [W-1:0] count_reg;

    // Count enabled cycles, holding at LIMIT instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT_C)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign reached = enable && !clear && (count_reg >= LAST_C);

endmodule

// File: rtl/inference_sequencer.sv
// Top-level OCR control: streams received bytes into the image buffer,
// launches one BNN inference per full frame, holds the digit for the host
// until acknowledged, and recovers from stalled loads or a hung core.
module inference_sequencer
    import bnn_ocr_pkg::*;
#(
    parameter int IMG_BYTES     = IMG_BYTES_C,
    parameter int LOAD_TIMEOUT  = LOAD_TIMEOUT_C,
    parameter int INFER_TIMEOUT = INFER_TIMEOUT_C,
    parameter int RESULT_W      = RESULT_W_C
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_valid,
    input  logic [7:0]          rx_byte,
    output logic                rx_ready,
    input  logic                host_clear,
    output logic                buf_clear,
    output logic                buf_write_request,
    output logic [7:0]          buf_data,
    input  logic                buf_write_ready,
    input  logic                buf_full,
    output logic                bnn_start,
    input  logic                bnn_done,
    input  logic [RESULT_W-1:0] bnn_result,
    output logic                result_valid,
    output logic [RESULT_W-1:0] result_digit,
    input  logic                result_ack,
    output logic                busy,
    output logic                timeout_err,
    output logic [2:0]          state_dbg
);

    localparam logic [6:0] LAST_BYTE_C = 7'(IMG_BYTES - 1);

    seq_state_t          state_reg;
    logic [6:0]          byte_cnt_reg;
    logic                result_valid_reg;
    logic [RESULT_W-1:0] result_digit_reg;
    logic                timeout_err_reg;

    logic in_load;
    logic accept;
    logic load_reached;
    logic infer_reached;

    // Bytes only move while loading; a host abort suppresses the write so
    // nothing of the aborted frame reaches the buffer in that cycle.
    assign in_load           = (state_reg == LOAD);
    assign rx_ready          = in_load & buf_write_ready;
    assign accept            = rx_valid & rx_ready & ~host_clear;
    assign buf_write_request = accept;
    assign buf_data          = rx_byte;

    assign buf_clear    = (state_reg == CLEAR);
    assign bnn_start    = (state_reg == INFER) & ~host_clear;
    assign busy         = !(in_load && (byte_cnt_reg == 7'd0));
    assign result_valid = result_valid_reg;
    assign result_digit = result_digit_reg;
    assign timeout_err  = timeout_err_reg;
    assign state_dbg    = state_reg;

    // Idle gap between bytes; only armed once a frame has started.
    timeout_counter #(
        .LIMIT (LOAD_TIMEOUT)
    ) u_load_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_load || accept),
        .enable  (in_load && (byte_cnt_reg != 7'd0)),
        .reached (load_reached)
    );

    // Time since launch; runs only while waiting for the core.
    timeout_counter #(
        .LIMIT (INFER_TIMEOUT)
    ) u_infer_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_reg != WAIT_DONE),
        .enable  (state_reg == WAIT_DONE),
        .reached (infer_reached)
    );

    // Sequencer FSM with registered result and timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= CLEAR;
            byte_cnt_reg     <= 7'd0;
            result_valid_reg <= 1'b0;
            result_digit_reg <= '0;
            timeout_err_reg  <= 1'b0;
        end else begin
            timeout_err_reg <= 1'b0;
            if (host_clear) begin
                state_reg        <= CLEAR;
                result_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    CLEAR: begin
                        byte_cnt_reg     <= 7'd0;
                        result_valid_reg <= 1'b0;
                        state_reg        <= LOAD;
                    end
                    LOAD: begin
                        if (accept) begin
                            byte_cnt_reg <= byte_cnt_reg + 7'd1;
                            if (byte_cnt_reg == LAST_BYTE_C) begin
                                state_reg <= WAIT_FULL;
                            end
                        end else if (load_reached) begin
                            // Partial frame is dropped; CLEAR wipes the buffer.
                            timeout_err_reg <= 1'b1;
                            state_reg       <= CLEAR;
                        end
                    end
                    WAIT_FULL: begin
                        if (buf_full) begin
                            state_reg <= INFER;
                        end
                    end
                    INFER: begin
                        state_reg <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        // A completion in the expiry cycle still counts.
                        if (bnn_done) begin
                            result_digit_reg <= bnn_result;
                            result_valid_reg <= 1'b1;
                            state_reg        <= RESULT;
                        end else if (infer_reached) begin
                            timeout_err_reg <= 1'b1;
                            state_reg       <= CLEAR;
                        end
                    end
                    RESULT: begin
                        if (result_ack) begin
                            result_valid_reg <= 1'b0;
                            state_reg        <= CLEAR;
                        end
                    end
                    default: begin
                        state_reg <= CLEAR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: table of frame scenarios, hand-written
// corner sequences and randomized frames checked against a byte-stream
// scoreboard and timing rules.
module tb_inference_sequencer;

    localparam int IMG = 113;
    localparam int LTO = 100;
    localparam int ITO = 64;
    localparam int S_CLEAR = 0, S_LOAD = 1, S_WAIT_DONE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       host_clear = 1'b0;
    logic       buf_write_ready = 1'b1;
    logic       bnn_done = 1'b0;
    logic [3:0] bnn_result = 4'h0;
    logic       result_ack = 1'b0;
    logic       rx_ready, buf_clear, buf_write_request, buf_full, bnn_start;
    logic       result_valid, busy, timeout_err;
    logic [7:0] buf_data;
    logic [3:0] result_digit;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    bit stall_en = 1'b0;

    always #5 clk = ~clk;

    inference_sequencer #(
        .LOAD_TIMEOUT  (LTO),
        .INFER_TIMEOUT (ITO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_valid          (rx_valid),
        .rx_byte           (rx_byte),
        .rx_ready          (rx_ready),
        .host_clear        (host_clear),
        .buf_clear         (buf_clear),
        .buf_write_request (buf_write_request),
        .buf_data          (buf_data),
        .buf_write_ready   (buf_write_ready),
        .buf_full          (buf_full),
        .bnn_start         (bnn_start),
        .bnn_done          (bnn_done),
        .bnn_result        (bnn_result),
        .result_valid      (result_valid),
        .result_digit      (result_digit),
        .result_ack        (result_ack),
        .busy              (busy),
        .timeout_err       (timeout_err),
        .state_dbg         (state_dbg)
    );

    // Image buffer stand-in: full one cycle after the 113th write.
    int fill = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 fill <= 0;
        else if (buf_clear)         fill <= 0;
        else if (buf_write_request) fill <= fill + 1;
    end
    assign buf_full = (fill >= IMG);

    // Event monitor sampled mid-cycle.
    int cyc = 0, n_wr = 0, n_clr = 0, n_start = 0, n_tmo = 0;
    int last_wr_cyc = 0, start_cyc = 0, tmo_cyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (buf_write_request) begin
                n_wr <= n_wr + 1;
                last_wr_cyc <= cyc;
                got_q.push_back(buf_data);
            end
            if (buf_clear) n_clr <= n_clr + 1;
            if (bnn_start) begin
                n_start <= n_start + 1;
                start_cyc <= cyc;
            end
            if (timeout_err) begin
                n_tmo <= n_tmo + 1;
                tmo_cyc <= cyc;
            end
        end
    end

    typedef struct {
        int nbytes;    // bytes offered back-to-back
        int done_dly;  // cycles after first WAIT_DONE cycle; -1 = never
        int result;
        int hold;      // cycles result is watched before ack
        int exp_wr;
        int exp_start;
        int exp_tmo;
        int exp_lat;   // timeout_err cycle minus last write / bnn_start
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        buf_write_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    // Offer n bytes; a byte is taken whenever the buffer is ready in LOAD.
    task automatic send_bytes(input int n, input int max_gap, output int acc);
        int bad_ready;
        bit taken;
        bad_ready = 0;
        acc = 0;
        for (int b = 0; b < n; b++) begin
            rx_valid = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
            rx_valid = 1'b1;
            rx_byte = 8'($urandom);
            taken = 1'b0;
            for (int w = 0; w < 50 && !taken; w++) begin
                @(negedge clk);
                if (rx_ready !== buf_write_ready) bad_ready++;
                if (buf_write_ready) begin
                    acc++;
                    exp_q.push_back(rx_byte);
                    taken = 1'b1;
                end
                step();
            end
        end
        rx_valid = 1'b0;
        check("rx_ready_follows_write_ready", bad_ready, 0);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bnn_start) ok = 1'b1;
            step();
        end
    endtask

    task automatic pulse_done(input int d, input logic [3:0] r);
        repeat (d) step();
        bnn_done = 1'b1;
        bnn_result = r;
        step();
        bnn_done = 1'b0;
        bnn_result = 4'($urandom);
    endtask

    task automatic check_stream(input string name);
        int bad;
        bad = 0;
        if (got_q.size() != exp_q.size()) bad++;
        else foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
        check(name, bad, 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int w0, c0, t0, s0, acc, held, vbad;
        bit ok;
        w0 = n_wr; c0 = n_clr; t0 = n_tmo; s0 = n_start;
        exp_q.delete(); got_q.delete();
        send_bytes(v.nbytes, 0, acc);
        if (v.done_dly >= 0) begin
            wait_start(ok);
            check("vec_start_seen", ok, 1);
            pulse_done(v.done_dly, 4'(v.result));
            held = 0;
            for (int i = 0; i < v.hold; i++) begin
                @(negedge clk);
                if (result_valid && result_digit == 4'(v.result)) held++;
                step();
            end
            check("vec_result_held", held, v.hold);
            @(negedge clk);
            check("vec_result_valid", result_valid, 1);
            check("vec_result_digit", result_digit, v.result);
            result_ack = 1'b1;
            step();
            result_ack = 1'b0;
            @(negedge clk);
            check("vec_clear_after_ack", buf_clear, 1);
            check("vec_valid_dropped", result_valid, 0);
            step();
        end else begin
            vbad = 0;
            for (int i = 0; i < 130; i++) begin
                @(negedge clk);
                if (result_valid) vbad++;
                step();
            end
            check("vec_no_result_on_timeout", vbad, 0);
        end
        @(negedge clk);
        check("vec_back_in_load", state_dbg, S_LOAD);
        check("vec_idle_not_busy", busy, 0);
        step();
        check("vec_writes", n_wr - w0, v.exp_wr);
        check("vec_starts", n_start - s0, v.exp_start);
        check("vec_timeouts", n_tmo - t0, v.exp_tmo);
        check("vec_clears", n_clr - c0, 1);
        if (v.exp_tmo != 0)
            check("vec_timeout_latency",
                  tmo_cyc - (v.exp_start != 0 ? start_cyc : last_wr_cyc), v.exp_lat);
        check_stream("vec_data_stream");
        $display("vec %0d: bytes=%0d done_dly=%0d result=%0d", idx, v.nbytes, v.done_dly, v.result);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, late, w0, c0;
        bit ok;

        vecs[0] = '{113, 5, 7, 50, 113, 1, 0, 0};
        vecs[1] = '{113, 0, 0, 3, 113, 1, 0, 0};
        vecs[2] = '{113, 62, 15, 1, 113, 1, 0, 0};
        vecs[3] = '{40, -1, 0, 0, 40, 0, 1, LTO + 1};
        vecs[4] = '{113, 2, 4, 0, 113, 1, 0, 0};
        vecs[5] = '{1, -1, 0, 0, 1, 0, 1, LTO + 1};
        vecs[6] = '{112, -1, 0, 0, 112, 0, 1, LTO + 1};
        vecs[7] = '{113, -1, 0, 0, 113, 1, 1, ITO + 1};
        vecs[8] = '{113, 1, 12, 2, 113, 1, 0, 0};

        // Reset values and the clear cycle after release.
        #1 rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_state", state_dbg, S_CLEAR);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_digit", result_digit, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_bnn_start", bnn_start, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_buf_clear", buf_clear, 1);
        step();
        @(negedge clk);
        check("post_rst_load", state_dbg, S_LOAD);
        check("post_rst_busy", busy, 0);
        check("post_rst_rx_ready", rx_ready, 1);
        step();
        $display("reset sequence done");

        // Stray done/ack while idle are ignored.
        bnn_done = 1'b1; result_ack = 1'b1;
        step();
        bnn_done = 1'b0; result_ack = 1'b0;
        @(negedge clk);
        check("stray_state", state_dbg, S_LOAD);
        check("stray_valid", result_valid, 0);
        step();
        $display("stray done/ack done");

        // host_clear coincident with the 60th byte.
        w0 = n_wr; c0 = n_clr;
        send_bytes(59, 0, acc);
        rx_valid = 1'b1; rx_byte = 8'hA5; host_clear = 1'b1;
        @(negedge clk);
        check("hc_write_gated", buf_write_request, 0);
        step();
        host_clear = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        check("hc_state_clear", state_dbg, S_CLEAR);
        check("hc_buf_clear", buf_clear, 1);
        step();
        @(negedge clk);
        check("hc_idle_not_busy", busy, 0);
        step();
        check("hc_writes", n_wr - w0, 59);
        check("hc_clears", n_clr - c0, 1);
        $display("host_clear on byte 60 done");

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // host_clear while holding a result.
        send_bytes(IMG, 0, acc);
        wait_start(ok);
        check("hcr_start_seen", ok, 1);
        pulse_done(3, 4'd9);
        @(negedge clk);
        check("hcr_valid_before", result_valid, 1);
        step();
        host_clear = 1'b1;
        step();
        host_clear = 1'b0;
        @(negedge clk);
        check("hcr_valid_dropped", result_valid, 0);
        check("hcr_state_clear", state_dbg, S_CLEAR);
        step(); step();
        $display("host_clear in RESULT done");

        // Receiver keeps offering 120 bytes; only one frame is taken.
        w0 = n_wr; acc = 0; late = 0;
        rx_valid = 1'b1; rx_byte = 8'($urandom);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                if (acc >= IMG) late++;
                else acc++;
            end
            step();
            if (acc < 120) rx_byte = 8'($urandom);
        end
        check("hold_accepted", acc, IMG);
        check("hold_no_ready_after_frame", late, 0);
        check("hold_writes", n_wr - w0, IMG);
        check("hold_state_wait_done", state_dbg, S_WAIT_DONE);
        pulse_done(0, 4'd2);
        @(negedge clk);
        check("hold_result", result_digit, 2);
        step();
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        @(negedge clk);
        check("hold_ready_low_in_clear", rx_ready, 0);
        step();
        rx_valid = 1'b0;
        @(negedge clk);
        check("hold_ready_back_in_load", rx_ready, 1);
        step();
        $display("120-byte hold done");

        // Async reset while a result is held.
        send_bytes(IMG, 0, acc);
        wait_start(ok);
        pulse_done(1, 4'd6);
        rst_n = 1'b0;
        #1;
        check("arst_valid_forced", result_valid, 0);
        check("arst_state_forced", state_dbg, S_CLEAR);
        check("arst_digit_forced", result_digit, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_buf_clear", buf_clear, 1);
        step(); step();
        $display("async reset done");

        // Randomized frames with receiver gaps and buffer backpressure.
        stall_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            int r, d, h, wf, sf;
            exp_q.delete(); got_q.delete();
            wf = n_wr; sf = n_start;
            send_bytes(IMG, 20, acc);
            check("rnd_accepted", acc, IMG);
            wait_start(ok);
            check("rnd_start_seen", ok, 1);
            check("rnd_start_latency", start_cyc - last_wr_cyc, 2);
            r = $urandom_range(0, 15);
            d = $urandom_range(0, 50);
            h = $urandom_range(0, 10);
            pulse_done(d, 4'(r));
            repeat (h) step();
            @(negedge clk);
            check("rnd_valid", result_valid, 1);
            check("rnd_digit", result_digit, r);
            result_ack = 1'b1;
            step();
            result_ack = 1'b0;
            step();
            @(negedge clk);
            check("rnd_back_in_load", state_dbg, S_LOAD);
            step();
            check("rnd_writes", n_wr - wf, IMG);
            check("rnd_one_start", n_start - sf, 1);
            check_stream("rnd_data_stream");
            $display("rnd frame %0d: result=%0d done_dly=%0d hold=%0d", f, r, d, h);
        end
        stall_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
Top-level control FSM for the OCR path. Accepts image bytes from the byte receiver and streams them into the 30x30 image buffer through its write_request/write_ready handshake. Once the buffer reports full, it launches one BNN inference and holds the classified digit for the host until acknowledged. It then clears the buffer for the next frame and recovers from stalled transfers or a hung core via timeouts.

Parameters:
IMG_BYTES, 113, bytes per frame (900 pixel bits packed; last byte uses low 4 bits only)
LOAD_TIMEOUT, 1_000_000, max idle cycles between bytes once a frame has started
INFER_TIMEOUT, 65_536, max cycles from bnn_start to bnn_done
RESULT_W, 4, width of the classification result

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_valid  in  1  receiver has a byte
rx_byte  in  8  received byte
rx_ready  out  1  sequencer accepts rx_byte this cycle
host_clear  in  1  abort/restart request, single-cycle pulse
buf_clear  out  1  clear strobe to image buffer
buf_write_request  out  1  write strobe to image buffer
buf_data  out  8  byte to image buffer
buf_write_ready  in  1  image buffer can accept a byte
buf_full  in  1  image buffer holds a full frame
bnn_start  out  1  one-cycle inference launch
bnn_done  in  1  inference complete, single-cycle pulse
bnn_result  in  RESULT_W  digit from BNN core, valid with bnn_done
result_valid  out  1  result_digit valid, held until ack
result_digit  out  RESULT_W  latched classification
result_ack  in  1  host consumed result
busy  out  1  high in every state except LOAD with byte count 0
timeout_err  out  1  one-cycle pulse on any timeout abort
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, rst_n low) drives: state CLEAR, byte_cnt 0, all timers 0, result_digit 0, result_valid 0, timeout_err 0, bnn_start 0. buf_clear asserts in the first cycle after reset release.
- States: CLEAR=0, LOAD=1, WAIT_FULL=2, INFER=3, WAIT_DONE=4, RESULT=5.
- CLEAR (1 cycle):
  - buf_clear=1; byte_cnt<=0; timers<=0; result_valid<=0.
  - Next state LOAD.
- LOAD:
  - rx_ready = buf_write_ready (combinational).
  - buf_write_request = rx_valid & rx_ready; buf_data = rx_byte, zero latency.
  - Each accepted byte increments byte_cnt (7-bit) and zeroes the load timer.
  - Accepting the byte that makes byte_cnt == IMG_BYTES goes to WAIT_FULL.
  - If byte_cnt>0 and the load timer reaches LOAD_TIMEOUT: pulse timeout_err, go to CLEAR (partial frame dropped).
  - The timer does not run while byte_cnt==0.
- WAIT_FULL:
  - rx_ready=0.
  - Waits for buf_full, which is expected 1 cycle after the last write; no timeout here.
  - On buf_full, go to INFER.
- INFER (1 cycle):
  - bnn_start=1; infer timer<=0.
  - Next state WAIT_DONE.
- WAIT_DONE:
  - On bnn_done: result_digit<=bnn_result; result_valid<=1; go to RESULT.
  - If the infer timer reaches INFER_TIMEOUT: pulse timeout_err, go to CLEAR.
- RESULT:
  - result_valid held high, result_digit stable.
  - On result_ack: result_valid<=0, go to CLEAR.
  - result_ack in any other state is ignored.
- bnn_done outside WAIT_DONE is ignored.
- rx_ready is 0 in every state except LOAD, so excess bytes stall at the receiver and are never dropped.
- host_clear has highest priority and applies in any state, including the same cycle as an accepted byte, bnn_done, or result_ack:
  - The next state is CLEAR.
  - result_valid drops at the next edge.
  - No write or start is issued in the host_clear cycle: buf_write_request and bnn_start are gated by ~host_clear.
- A simultaneous timeout and host_clear produces no timeout_err.
- Timers saturate; they never wrap.
- Async reset mid-frame: the outputs above are forced immediately. The buffer is re-cleared via CLEAR after release.

Decomposition:
- Package bnn_ocr_pkg holds:
  - typedef enum logic [2:0] seq_state_t with the encodings above;
  - IMG_BYTES_C=113;
  - RESULT_W_C=4.
- One sub-module, timeout_counter: a parameterised saturating counter with clear/enable and a reached flag. It is instantiated twice, for the load and infer timers.

Test Plan:
- Reset, then stream 113 bytes back-to-back with rx_valid held -> 113 buf_write_request pulses and one buf_clear after reset; WAIT_FULL entered after byte 113; exactly one bnn_start 1 cycle after buf_full.
- bnn_done with bnn_result=7 -> result_valid=1, result_digit=7 held for 50 cycles without ack; result_ack -> one buf_clear, then LOAD with busy=0.
- Send 40 bytes then stop for LOAD_TIMEOUT cycles (bench uses LOAD_TIMEOUT=100) -> one timeout_err pulse, buf_clear, byte_cnt 0; a following full frame completes normally.
- Full frame loaded, bnn_done never arrives (INFER_TIMEOUT=64) -> timeout_err 65 cycles after bnn_start; result_valid stays 0.
- host_clear in the same cycle as the 60th accepted byte -> no buf_write_request that cycle, CLEAR next; after host_clear in RESULT, result_valid=0 within 1 cycle.
- Hold rx_valid high for 120 bytes -> exactly 113 accepted; rx_ready=0 until CLEAR/LOAD of the next frame.
